// File: rtl/fb_dbuf_bram_if.sv
// Port bundle for the double-buffered frame store: back-page writes, front-page reads,
// swap control and the clear engine handshake.
interface fb_dbuf_bram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              vsync;
  logic              swap_req;
  logic              swap_pending;
  logic              front_page;
  logic              clr_req;
  logic [DATA_W-1:0] clr_data;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, vsync, swap_req, clr_req, clr_data,
    input  rd_data, swap_pending, front_page, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, vsync, swap_req, clr_req, clr_data,
    output rd_data, swap_pending, front_page, clr_busy, clr_done
  );
endinterface

// File: rtl/fb_dbuf_bram.sv
// Two-page frame buffer in one block RAM: display reads the front page (1-cycle registered),
// writes and the rectangular clear engine target the back page; swaps land on vsync only.
module fb_dbuf_bram #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 14,
  parameter int COLS        = 100,
  parameter int ROWS        = 75,
  parameter int STRIDE_LOG2 = 7
) (
  input logic          clk,
  input logic          rst,
  fb_dbuf_bram_if.slave bus
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DEPTH = 1 << (ADDR_W + 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_fill_data;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic              r_front;
  logic              r_pending;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_swap;

  assign w_fill_addr = (ADDR_W'(r_row) << STRIDE_LOG2) + ADDR_W'(r_col);
  assign w_col_last  = (r_col == COL_W'(COLS - 1));
  assign w_row_last  = (r_row == ROW_W'(ROWS - 1));

  // The clear engine owns the write port while busy; user writes are simply dropped.
  assign w_we    = ~rst & (r_clr_busy | bus.wr_en);
  assign w_waddr = r_clr_busy ? w_fill_addr : bus.wr_addr;
  assign w_wdata = r_clr_busy ? r_fill_data : bus.wr_data;

  // Swaps are held off while clearing so a fill never migrates to the displayed page.
  assign w_swap = bus.vsync & r_pending & ~r_clr_busy;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[{~r_front, w_waddr}] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[{r_front, bus.rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_swap) begin
      r_front   <= ~r_front;
      r_pending <= 1'b0;
    end else if (bus.swap_req) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_fill_data <= '0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.clr_req) begin
            r_fill_data <= bus.clr_data;
            r_col       <= '0;
            r_row       <= '0;
            r_clr_busy  <= 1'b1;
            r_state     <= FILL;
          end
        end
        FILL: begin
          if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) begin
              r_row      <= '0;
              r_clr_busy <= 1'b0;
              r_clr_done <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.swap_pending = r_pending;
  assign bus.front_page   = r_front;
  assign bus.clr_busy     = r_clr_busy;
  assign bus.clr_done     = r_clr_done;

endmodule

// File: doc/fb_dbuf_bram.md
FB_DBUF_BRAM -- requirements
Module: fb_dbuf_bram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter ADDR_W, default 14, per-page address width; page depth is 2^ADDR_W.
REQ-003 SHALL have parameter COLS, default 100, visible columns.
REQ-004 SHALL have parameter ROWS, default 75, visible rows.
REQ-005 SHALL have parameter STRIDE_LOG2, default 7; pixel address = row*2^STRIDE_LOG2 + col.
REQ-006 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write strobe into the back page.
REQ-009 SHALL have port wr_addr  input  ADDR_W  back-page write address.
REQ-010 SHALL have port wr_data  input  DATA_W  write pixel.
REQ-011 SHALL have port rd_addr  input  ADDR_W  front-page read address.
REQ-012 SHALL have port rd_data  output  DATA_W  registered front-page read data.
REQ-013 SHALL have port vsync  input  1  single-cycle frame-boundary pulse.
REQ-014 SHALL have port swap_req  input  1  pulse requesting a front/back exchange.
REQ-015 SHALL have port swap_pending  output  1  swap requested but not yet applied.
REQ-016 SHALL have port front_page  output  1  index of the page currently displayed.
REQ-017 SHALL have port clr_req  input  1  pulse starting a back-page clear.
REQ-018 SHALL have port clr_data  input  DATA_W  fill value, sampled on an accepted clr_req.
REQ-019 SHALL have port clr_busy  output  1  clear engine active.
REQ-020 SHALL have port clr_done  output  1  single-cycle pulse on clear completion.

Function
REQ-021 SHALL hold 2*2^ADDR_W words in one inferred block RAM; physical address = {page, addr}.
REQ-022 SHALL read {front_page, rd_addr} every cycle, with rd_data valid exactly 1 cycle after rd_addr.
REQ-023 SHALL direct every write to {~front_page, addr}; the display port never sees a write in progress.
REQ-024 SHALL accept user writes only when clr_busy=0; wr_en with clr_busy=1 is dropped silently.
REQ-025 SHALL run the clear engine as an FSM with states IDLE and FILL.
REQ-026 SHALL accept clr_req in IDLE only, latch clr_data, zero row/col counters, and enter FILL with clr_busy=1 from the next cycle.
REQ-027 SHALL in FILL write one pixel per cycle at row*2^STRIDE_LOG2+col, incrementing col 0..COLS-1, then wrapping col to 0 and incrementing row.
REQ-028 SHALL leave addresses with col>=COLS untouched.
REQ-029 SHALL, after writing (ROWS-1, COLS-1), return to IDLE, drop clr_busy, and pulse clr_done for one cycle; a full clear takes ROWS*COLS cycles.
REQ-030 SHALL ignore clr_req while in FILL.
REQ-031 SHALL set swap_pending on swap_req; swap_req while swap_pending=1 has no further effect.
REQ-032 SHALL toggle front_page and clear swap_pending on the first vsync with swap_pending=1 and clr_busy=0.
REQ-033 SHALL, when vsync and swap_req coincide with swap_pending=0, set swap_pending and defer the swap to the next qualifying vsync.
REQ-034 SHALL keep a clear that is in progress on its original page; a swap is never applied while clr_busy=1.
REQ-035 SHALL apply front_page changes to reads issued from the following cycle onward.

Reset
REQ-036 SHALL on rst drive rd_data=0, front_page=0, swap_pending=0, clr_busy=0, clr_done=0, FSM=IDLE, counters=0.
REQ-037 SHALL on rst mid-FILL abort the clear without a clr_done pulse; pixels already written stay written.
REQ-038 SHALL NOT initialise or clear RAM contents on rst.
REQ-039 SHALL give rst priority over all other inputs in the same cycle.

Verification
REQ-040 SHALL cover: write 0xA5 to addr 0x0105 on back page, swap_req, vsync -> front_page=1, read 0x0105 returns 0xA5 one cycle later.
REQ-041 SHALL cover: clr_req with clr_data=0x1C -> clr_busy for 7500 cycles, clr_done once; after swap, addr 0x2563 reads 0x1C and addr 0x0064 (col 100) is unchanged.
REQ-042 SHALL cover: swap_req during FILL plus vsync mid-clear -> no toggle; the first vsync after clr_done toggles front_page.
REQ-043 SHALL cover: wr_en during FILL at addr 0x0000 with 0xFF -> value after clear is clr_data, not 0xFF.
REQ-044 SHALL cover: rst asserted at FILL cycle 300 -> all outputs at reset values next cycle, no clr_done, and a subsequent clr_req is accepted.
REQ-045 SHALL cover: a second swap_req while pending, then two vsyncs -> front_page toggles exactly once.
